// File: rtl/matdet_stream_if.sv
// Element stream, flattened matrix bus, determinant return and result handshake for matdet_stream_ctrl.
// Zero latency: wiring only; every signal is driven by exactly one side.
// Backpressure: in_ready and det_ready carry flow control; the singular flag exists only with MATDET_SINGULAR_EN.
interface matdet_stream_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 3
);
    localparam int MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [MAT_W-1:0]      mat_out;
    logic                  mat_valid;
    logic [DATA_WIDTH-1:0] det_in;
    logic [DATA_WIDTH-1:0] det_out;
    logic                  det_valid;
    logic                  det_ready;
`ifdef MATDET_SINGULAR_EN
    logic                  singular;
`endif

    // Producer / consumer / core side
    modport master (
        output in_data, in_valid, det_in, det_ready,
        input  in_ready, mat_out, mat_valid, det_out, det_valid
`ifdef MATDET_SINGULAR_EN
        , input singular
`endif
    );

    // Stream controller side
    modport slave (
        input  in_data, in_valid, det_in, det_ready,
        output in_ready, mat_out, mat_valid, det_out, det_valid
`ifdef MATDET_SINGULAR_EN
        , output singular
`endif
    );
endinterface

// File: rtl/matdet_stream_ctrl.sv
// Collects N*N row-major elements into a flat matrix for a combinational determinant core and returns its result.
// Latency: det_valid rises SETTLE_CYCLES+1 edges after the last element is accepted.
// Backpressure: in_ready is low from the last accept until the det_valid/det_ready handshake; optional flag via MATDET_SINGULAR_EN.
module matdet_stream_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int BIN_POS       = 8,
    parameter int MATRIX_SIZE   = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    matdet_stream_if.slave bus
);
    localparam int NUM_ELEM = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CNT_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_ELEM   = CNT_W'(NUM_ELEM - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES);

    // Data is opaque here; the binary point only has to lie inside the word.
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("matdet_stream_ctrl: SETTLE_CYCLES must be at least 1");
        end
        if (BIN_POS < 0 || BIN_POS > DATA_WIDTH) begin : g_bad_bin_pos
            $error("matdet_stream_ctrl: BIN_POS outside the data word");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      elem_cnt;
    logic [SET_W-1:0]      settle_cnt;
    logic [DATA_WIDTH-1:0] elem [NUM_ELEM];
    logic                  in_ready_q;
    logic                  mat_valid_q;
    logic [DATA_WIDTH-1:0] det_out_q;
    logic                  det_valid_q;
`ifdef MATDET_SINGULAR_EN
    logic                  singular_q;
`endif

    // Control FSM; every output is a register so nothing combinational reaches the ports.
    // The settle counter runs 0..SETTLE_CYCLES: mat_out is complete at the last accept edge and
    // the core gets SETTLE_CYCLES full cycles of stable input before the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            elem_cnt    <= '0;
            settle_cnt  <= '0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                elem[i] <= '0;
            end
            in_ready_q  <= 1'b1;
            mat_valid_q <= 1'b0;
            det_out_q   <= '0;
            det_valid_q <= 1'b0;
`ifdef MATDET_SINGULAR_EN
            singular_q  <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        elem[elem_cnt] <= bus.in_data;
                        if (elem_cnt == LAST_ELEM) begin
                            elem_cnt    <= '0;
                            settle_cnt  <= '0;
                            in_ready_q  <= 1'b0;
                            mat_valid_q <= 1'b1;
                            state       <= SETTLE;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        det_out_q   <= bus.det_in;
                        det_valid_q <= 1'b1;
`ifdef MATDET_SINGULAR_EN
                        singular_q  <= (bus.det_in == '0);
`endif
                        settle_cnt  <= '0;
                        state       <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                OUT: begin
                    // mat_out keeps its old contents; the next matrix overwrites slot by slot.
                    if (bus.det_ready) begin
                        det_valid_q <= 1'b0;
                        mat_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef MATDET_SINGULAR_EN
                        singular_q  <= 1'b0;
`endif
                        state       <= LOAD;
                    end
                end
                default: begin
                    state      <= LOAD;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Flatten the element registers onto the core bus, element i at bit i*DATA_WIDTH.
    logic [NUM_ELEM*DATA_WIDTH-1:0] mat_flat;
    always_comb begin
        mat_flat = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            mat_flat[i*DATA_WIDTH +: DATA_WIDTH] = elem[i];
        end
    end

    assign bus.mat_out   = mat_flat;
    assign bus.mat_valid = mat_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.det_out   = det_out_q;
    assign bus.det_valid = det_valid_q;
`ifdef MATDET_SINGULAR_EN
    assign bus.singular  = singular_q;
`endif

endmodule

// File: tb/tb_matdet_stream_ctrl.sv
// Directed bench for matdet_stream_ctrl with a behavioural Q8.8 3x3 determinant core.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Singular-flag checks are compiled in when MATDET_SINGULAR_EN is defined.
`timescale 1ns/1ps
module tb_matdet_stream_ctrl;
    localparam int DW = 16;
    localparam int N  = 3;
    localparam int NE = N * N;
    localparam int MW = NE * DW;

    typedef logic [DW-1:0] mat_t [NE];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    matdet_stream_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(N)) bus ();

    matdet_stream_ctrl #(
        .DATA_WIDTH(DW), .BIN_POS(8), .MATRIX_SIZE(N), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Q8.8 determinant by cofactor expansion; triple products carry 24 fraction bits, scaled back by 16.
    function automatic logic [DW-1:0] ref_det(input mat_t m);
        longint x [NE];
        longint full;
        for (int k = 0; k < NE; k++) x[k] = longint'($signed(m[k]));
        full = x[0] * (x[4] * x[8] - x[5] * x[7])
             - x[1] * (x[3] * x[8] - x[5] * x[6])
             + x[2] * (x[3] * x[7] - x[4] * x[6]);
        return DW'(full >>> 16);
    endfunction

    function automatic logic [DW-1:0] core_det(input logic [MW-1:0] flat);
        mat_t m;
        for (int k = 0; k < NE; k++) m[k] = flat[k*DW +: DW];
        return ref_det(m);
    endfunction

    function automatic logic [MW-1:0] pack(input mat_t m);
        logic [MW-1:0] f;
        f = '0;
        for (int k = 0; k < NE; k++) f[k*DW +: DW] = m[k];
        return f;
    endfunction

    assign bus.det_in = core_det(bus.mat_out);

    // Feed up to 'count' elements; returns right after the edge that took the last one.
    task automatic push_matrix(input mat_t m, input int count, input bit gap, output int accepted);
        int   cyc;
        logic take;
        cyc = 0;
        accepted = 0;
        while (accepted < count && cyc < 100) begin
            @(negedge clk);
            if (gap && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = m[accepted];
            end
            take = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (take) accepted++;
            cyc++;
        end
    endtask

    // Walk falling edges until det_valid; lat=1 is the falling edge right after the last accept.
    task automatic wait_det(output int lat, output logic rdy_first);
        lat = 0;
        rdy_first = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.in_valid = 1'b0;
                rdy_first = bus.in_ready;
            end
            if (bus.det_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.det_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.mat_valid !== 1'b0) begin errors++; $display("FAIL rst_mat_valid: got %b want 0", bus.mat_valid); end
        checks++; if (bus.det_valid !== 1'b0) begin errors++; $display("FAIL rst_det_valid: got %b want 0", bus.det_valid); end
        checks++; if (bus.det_out !== 16'h0000) begin errors++; $display("FAIL rst_det_out: got %h want 0000", bus.det_out); end
        checks++; if (bus.mat_out !== '0) begin errors++; $display("FAIL rst_mat_out: got %h want 0", bus.mat_out); end
`ifdef MATDET_SINGULAR_EN
        checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL rst_singular: got %b want 0", bus.singular); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        mat_t m;
        int   acc, lat;
        logic rdy1;
        for (int k = 0; k < NE; k++) m[k] = (k % 4 == 0) ? 16'h0100 : 16'h0000;
        bus.det_ready = 1'b1;
        push_matrix(m, NE, 1'b0, acc);
        wait_det(lat, rdy1);
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL id_settle_in_ready: got %b want 0", rdy1); end
        checks++; if (lat != 4) begin errors++; $display("FAIL id_latency: got %0d want 4", lat); end
        checks++; if (bus.det_out !== 16'h0100) begin errors++; $display("FAIL id_det: got %h want 0100", bus.det_out); end
        checks++; if (bus.mat_valid !== 1'b1) begin errors++; $display("FAIL id_mat_valid: got %b want 1", bus.mat_valid); end
        checks++; if (bus.mat_out !== pack(m)) begin errors++; $display("FAIL id_mat_out: got %h want %h", bus.mat_out, pack(m)); end
        @(negedge clk);
        checks++; if (bus.det_valid !== 1'b0) begin errors++; $display("FAIL id_det_valid_pulse: got %b want 0", bus.det_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL id_in_ready_after: got %b want 1", bus.in_ready); end
        checks++; if (bus.mat_valid !== 1'b0) begin errors++; $display("FAIL id_mat_valid_after: got %b want 0", bus.mat_valid); end
    endtask

    task automatic test_gapped();
        mat_t m;
        int   acc, lat;
        logic rdy1;
        for (int k = 0; k < NE; k++) m[k] = 16'h0000;
        m[0] = 16'h0200; m[4] = 16'h0300; m[8] = 16'h0400;
        bus.det_ready = 1'b1;
        push_matrix(m, NE, 1'b1, acc);
        checks++; if (acc != NE) begin errors++; $display("FAIL gap_accepts: got %0d want 9", acc); end
        wait_det(lat, rdy1);
        checks++; if (lat != 4) begin errors++; $display("FAIL gap_latency: got %0d want 4", lat); end
        checks++; if (bus.det_out !== 16'h1800) begin errors++; $display("FAIL gap_det: got %h want 1800", bus.det_out); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        mat_t m;
        int   acc, lat;
        logic rdy1;
        for (int k = 0; k < NE; k++) m[k] = 16'h0000;
        m[0] = 16'h0100; m[1] = 16'h0100; m[4] = 16'h0200; m[8] = 16'h0100;
        bus.det_ready = 1'b0;
        push_matrix(m, NE, 1'b0, acc);
        wait_det(lat, rdy1);
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h7777;
            checks++; if (bus.det_valid !== 1'b1) begin errors++; $display("FAIL bp_det_valid[%0d]: got %b want 1", c, bus.det_valid); end
            checks++; if (bus.det_out !== 16'h0200) begin errors++; $display("FAIL bp_det_out[%0d]: got %h want 0200", c, bus.det_out); end
            checks++; if (bus.mat_out !== pack(m)) begin errors++; $display("FAIL bp_mat_out[%0d]: got %h want %h", c, bus.mat_out, pack(m)); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.det_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.det_valid !== 1'b0) begin errors++; $display("FAIL bp_release_det_valid: got %b want 0", bus.det_valid); end
        checks++; if (bus.mat_out !== pack(m)) begin errors++; $display("FAIL bp_mat_out_kept: got %h want %h", bus.mat_out, pack(m)); end
    endtask

    task automatic test_reset_mid_load();
        mat_t m;
        mat_t id;
        int   acc, lat;
        logic rdy1;
        for (int k = 0; k < NE; k++) m[k] = DW'((k + 1) * 16'h0111);
        for (int k = 0; k < NE; k++) id[k] = (k % 4 == 0) ? 16'h0100 : 16'h0000;
        push_matrix(m, 4, 1'b0, acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.mat_out !== '0) begin errors++; $display("FAIL mid_rst_mat_out: got %h want 0", bus.mat_out); end
        checks++; if (bus.det_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_det_valid: got %b want 0", bus.det_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.det_ready = 1'b1;
        push_matrix(id, NE, 1'b0, acc);
        wait_det(lat, rdy1);
        checks++; if (lat != 4) begin errors++; $display("FAIL mid_latency: got %0d want 4", lat); end
        checks++; if (bus.det_out !== 16'h0100) begin errors++; $display("FAIL mid_det: got %h want 0100", bus.det_out); end
        checks++; if (bus.mat_out !== pack(id)) begin errors++; $display("FAIL mid_mat_out: got %h want %h", bus.mat_out, pack(id)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] elems [$];
        logic [DW-1:0] exp_q [$];
        mat_t          m;
        int            idx, got, cyc;
        logic          take;
        idx = 0; got = 0; cyc = 0;
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < NE; k++) begin
                int v;
                v = int'($urandom_range(18, 0)) - 9;
                m[k] = DW'(v * 256);
                elems.push_back(m[k]);
            end
            exp_q.push_back(ref_det(m));
        end
        bus.det_ready = 1'b1;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            if (bus.det_valid === 1'b1) begin
                checks++;
                if (bus.det_out !== exp_q[got]) begin
                    errors++;
                    $display("FAIL b2b_det[%0d]: got %h want %h", got, bus.det_out, exp_q[got]);
                end
                got++;
            end
            if (idx < elems.size()) begin
                bus.in_valid = 1'b1;
                bus.in_data  = elems[idx];
                take = bus.in_ready;
            end else begin
                bus.in_valid = 1'b0;
                take = 1'b0;
            end
            @(posedge clk);
            if (take === 1'b1) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 20) begin errors++; $display("FAIL b2b_results: got %0d want 20", got); end
        @(negedge clk);
    endtask

`ifdef MATDET_SINGULAR_EN
    task automatic test_singular();
        mat_t m;
        int   acc, lat;
        logic rdy1;
        for (int k = 0; k < NE; k++) m[k] = 16'h0100;
        bus.det_ready = 1'b1;
        push_matrix(m, NE, 1'b0, acc);
        wait_det(lat, rdy1);
        checks++; if (bus.det_out !== 16'h0000) begin errors++; $display("FAIL sing_det: got %h want 0000", bus.det_out); end
        checks++; if (bus.singular !== 1'b1) begin errors++; $display("FAIL sing_flag: got %b want 1", bus.singular); end
        @(negedge clk);
        checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL sing_clear: got %b want 0", bus.singular); end
        for (int k = 0; k < NE; k++) m[k] = (k % 4 == 0) ? 16'h0100 : 16'h0000;
        push_matrix(m, NE, 1'b0, acc);
        wait_det(lat, rdy1);
        checks++; if (bus.det_out !== 16'h0100) begin errors++; $display("FAIL nonsing_det: got %h want 0100", bus.det_out); end
        checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL nonsing_flag: got %b want 0", bus.singular); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_gapped();
        test_backpressure();
        test_reset_mid_load();
        test_back_to_back();
`ifdef MATDET_SINGULAR_EN
        test_singular();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
